sdram_port_arb: RTL and testbench
=================================

Name: sdram_port_arb

Overview:
Round-robin arbiter that shares the single SDRAM (MIG) command port among the accelerator's memory requesters. The requesters are: command fetch (req 0), data fetch, weight fetch and result write-back.
- Grants one requester at a time.
- Issues exactly one MIG command per grant.
- For reads, holds the grant until the burst's data beats have been consumed.
Sits between the CSB/engines and the MIG user port.

Parameters:
NREQ, 4, number of requesters (index 0 = command fetch)
ADDR_W, 30, MIG byte address width
BL_W, 6, burst-length field width (beats = bl+1, 1..64)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
req  in  NREQ  request per requester, held until matching done
req_wr  in  NREQ  1=write burst, 0=read burst
req_addr  in  NREQ*ADDR_W  flattened start address, slice i = requester i
req_bl  in  NREQ*BL_W  flattened burst length minus one
gnt  out  NREQ  one-hot grant
done  out  NREQ  one-cycle completion pulse per requester
cmd_en  out  1  MIG command strobe
cmd_instr  out  3  3'b000 write, 3'b001 read
cmd_addr  out  ADDR_W  MIG command address
cmd_bl  out  BL_W  MIG burst length
cmd_full  in  1  MIG command FIFO full
beat_strobe  in  1  one read data beat consumed by the granted requester
busy  out  1  high when state != IDLE
err  out  1  sticky protocol error

Behaviour:
- Reset (async, any state): state=IDLE, all outputs 0, rr_ptr=NREQ-1, beat counter 0. A burst in flight is abandoned and no done is issued.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If |req at the clock edge, select a winner by round-robin: scan from (rr_ptr+1) mod NREQ upward and wrap.
  - Register gnt=onehot(winner), cmd_addr/cmd_bl from the winner's slice, cmd_instr from req_wr[winner].
  - Go to ISSUE. If no request, stay in IDLE.
- ISSUE:
  - If cmd_full=0 at the edge: cmd_en<=1, clear beat counter, go to WAIT.
  - Otherwise hold, with cmd_en=0.
- WAIT:
  - cmd_en<=0 in the first WAIT cycle, so cmd_en is high for exactly one cycle per grant.
  - Write: on the first WAIT cycle, done[winner]<=1, gnt<=0, rr_ptr<=winner, go to IDLE. The requester must have filled the MIG write FIFO before raising req.
  - Read: count beat_strobe, where count is 7 bits. Beats in the cycle cmd_en is high are counted. When the count reaches cmd_bl+1: done[winner]<=1, gnt<=0, rr_ptr<=winner, go to IDLE.
- done is a registered one-cycle pulse. IDLE arbitrates again in the cycle after done, so there is always at least one idle cycle between grants.
- Latency: req sampled at edge N -> gnt at N+1 -> earliest cmd_en at N+2.
- Requester rules: req, req_wr, req_addr and req_bl must stay stable from req rise to done. Inputs are captured at grant, so later changes do not alter the issued command. A req drop during ISSUE/WAIT is ignored and the burst completes normally.
- A requester holding req after its done is re-eligible, but only after all other pending requesters have been served.
- err<=1 (sticky until rst) when either:
  - beat_strobe=1 outside WAIT-read, or
  - beat_strobe arrives after the count has already reached cmd_bl+1.
- busy = (state!=IDLE), registered with the state.

Optional Feature:
ARB_FIXED_PRIO0_EN
- Defined: req[0] (command fetch) wins whenever asserted in IDLE, regardless of rr_ptr. rr_ptr is not updated by grants to requester 0. The remaining requesters rotate round-robin among themselves.
- Undefined: pure round-robin over all NREQ requesters.

Test Plan:
1. From reset, req[1] read, addr 0x00A0000, bl 7 -> gnt=4'b0010 one cycle later; cmd_en single pulse with instr 3'b001, addr 0x00A0000, bl 7; after 8 beat_strobe, done[1] one-cycle pulse, gnt=0, busy=0.
2. From reset, req=4'b1111 held, all reads with bl 0 and one beat each -> grants in order 0,1,2,3,0. Exactly one cmd_en per grant; one idle cycle between grants.
3. req[3] write, bl 15, cmd_full held high for 5 cycles in ISSUE -> cmd_en stays low; cmd_en pulses in the cycle after cmd_full falls; done[3] the following cycle; no beat counting.
4. beat_strobe pulsed in IDLE -> err=1 and stays 1 through later normal bursts until rst.
5. rst asserted after 3 of 8 read beats -> all outputs 0 immediately and no done. A new req[2] read with bl 1 then completes normally after 2 beats.
6. req[0] and req[2] held with reads of bl 0: with ARB_FIXED_PRIO0_EN, every grant goes to 0; without the macro, grants alternate 0,2,0,2.

Source files
------------

// File: rtl/sdram_port_arb.sv
// sdram_port_arb: round-robin arbiter sharing the single MIG command port
// among NREQ memory requesters (index 0 = command fetch). One MIG command is
// issued per grant; read grants are held until all burst beats are consumed.
// Optional build macro ARB_FIXED_PRIO0_EN: requester 0 always wins in IDLE and
// never moves the round-robin pointer; the others rotate among themselves.
module sdram_port_arb #(
    parameter int NREQ   = 4,
    parameter int ADDR_W = 30,
    parameter int BL_W   = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        req_wr,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*BL_W-1:0]   req_bl,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        done,
    output logic                   cmd_en,
    output logic [2:0]             cmd_instr,
    output logic [ADDR_W-1:0]      cmd_addr,
    output logic [BL_W-1:0]        cmd_bl,
    input  logic                   cmd_full,
    input  logic                   beat_strobe,
    output logic                   busy,
    output logic                   err
);

    localparam logic [2:0] INSTR_WR = 3'b000;
    localparam logic [2:0] INSTR_RD = 3'b001;
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = BL_W + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

    state_t              state_reg, state_next;
    logic [NREQ-1:0]     gnt_reg, gnt_next;
    logic [NREQ-1:0]     done_reg, done_next;
    logic                cmd_en_reg, cmd_en_next;
    logic [2:0]          cmd_instr_reg, cmd_instr_next;
    logic [ADDR_W-1:0]   cmd_addr_reg, cmd_addr_next;
    logic [BL_W-1:0]     cmd_bl_reg, cmd_bl_next;
    logic                busy_reg, busy_next;
    logic                err_reg, err_next;
    logic [PTR_W-1:0]    rr_ptr_reg, rr_ptr_next;
    logic [PTR_W-1:0]    win_reg, win_next;
    logic [CNT_W-1:0]    beat_cnt_reg, beat_cnt_next;

    logic [ADDR_W-1:0]   addr_arr [NREQ];
    logic [BL_W-1:0]     bl_arr   [NREQ];
    logic [PTR_W-1:0]    sel_idx;
    logic                sel_valid;
    logic                finish;
    logic                wait_read;
    logic [CNT_W-1:0]    beat_target;

    // Unpack the flattened per-requester address and burst-length buses.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
            assign bl_arr[gi]   = req_bl[gi*BL_W +: BL_W];
        end
    endgenerate

    assign beat_target = {1'b0, cmd_bl_reg} + CNT_W'(1);
    assign wait_read   = (state_reg == ST_WAIT) && (cmd_instr_reg == INSTR_RD);

    // Winner selection: scan upward from the requester after the last winner.
    always_comb begin
        logic [PTR_W-1:0] cand;
        cand      = '0;
        sel_idx   = '0;
        sel_valid = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = PTR_W'((int'(rr_ptr_reg) + k) % NREQ);
            if (!sel_valid && req[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = cand;
            end
        end
`ifdef ARB_FIXED_PRIO0_EN
        if (req[0]) begin
            sel_valid = 1'b1;
            sel_idx   = '0;
        end
`endif
    end

    // Next-state and registered-output logic for the IDLE/ISSUE/WAIT sequence.
    always_comb begin
        state_next     = state_reg;
        gnt_next       = gnt_reg;
        done_next      = '0;
        cmd_en_next    = 1'b0;
        cmd_instr_next = cmd_instr_reg;
        cmd_addr_next  = cmd_addr_reg;
        cmd_bl_next    = cmd_bl_reg;
        err_next       = err_reg;
        rr_ptr_next    = rr_ptr_reg;
        win_next       = win_reg;
        beat_cnt_next  = beat_cnt_reg;
        finish         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (sel_valid) begin
                    state_next     = ST_ISSUE;
                    win_next       = sel_idx;
                    gnt_next       = NREQ'(1) << sel_idx;
                    cmd_addr_next  = addr_arr[sel_idx];
                    cmd_bl_next    = bl_arr[sel_idx];
                    cmd_instr_next = req_wr[sel_idx] ? INSTR_WR : INSTR_RD;
                end
            end
            ST_ISSUE: begin
                if (!cmd_full) begin
                    cmd_en_next   = 1'b1;
                    beat_cnt_next = '0;
                    state_next    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Writes complete at once: the write FIFO was filled before req.
                if (cmd_instr_reg == INSTR_WR) begin
                    finish = 1'b1;
                end else if (beat_strobe) begin
                    beat_cnt_next = beat_cnt_reg + CNT_W'(1);
                    if (beat_cnt_next == beat_target) begin
                        finish = 1'b1;
                    end
                end
                if (finish) begin
                    done_next  = NREQ'(1) << win_reg;
                    gnt_next   = '0;
                    state_next = ST_IDLE;
`ifdef ARB_FIXED_PRIO0_EN
                    if (win_reg != '0) begin
                        rr_ptr_next = win_reg;
                    end
`else
                    rr_ptr_next = win_reg;
`endif
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // A beat is only legal while a read burst still has beats outstanding.
        if (beat_strobe && (!wait_read || (beat_cnt_reg >= beat_target))) begin
            err_next = 1'b1;
        end

        busy_next = (state_next != ST_IDLE);
    end

    // State and output registers; reset abandons any burst without a done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            gnt_reg       <= '0;
            done_reg      <= '0;
            cmd_en_reg    <= 1'b0;
            cmd_instr_reg <= '0;
            cmd_addr_reg  <= '0;
            cmd_bl_reg    <= '0;
            busy_reg      <= 1'b0;
            err_reg       <= 1'b0;
            rr_ptr_reg    <= PTR_W'(NREQ - 1);
            win_reg       <= '0;
            beat_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            gnt_reg       <= gnt_next;
            done_reg      <= done_next;
            cmd_en_reg    <= cmd_en_next;
            cmd_instr_reg <= cmd_instr_next;
            cmd_addr_reg  <= cmd_addr_next;
            cmd_bl_reg    <= cmd_bl_next;
            busy_reg      <= busy_next;
            err_reg       <= err_next;
            rr_ptr_reg    <= rr_ptr_next;
            win_reg       <= win_next;
            beat_cnt_reg  <= beat_cnt_next;
        end
    end

    assign gnt       = gnt_reg;
    assign done      = done_reg;
    assign cmd_en    = cmd_en_reg;
    assign cmd_instr = cmd_instr_reg;
    assign cmd_addr  = cmd_addr_reg;
    assign cmd_bl    = cmd_bl_reg;
    assign busy      = busy_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_sdram_port_arb.sv
// tb_sdram_port_arb: directed, table-driven bench for sdram_port_arb.
// Single-requester bursts come from a vector table; arbitration order,
// command back-pressure, protocol error and mid-burst reset are hand sequences.
module tb_sdram_port_arb;

    localparam int NREQ   = 4;
    localparam int ADDR_W = 30;
    localparam int BL_W   = 6;

    logic                   clk;
    logic                   rst;
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        req_wr;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*BL_W-1:0]   req_bl;
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        done;
    logic                   cmd_en;
    logic [2:0]             cmd_instr;
    logic [ADDR_W-1:0]      cmd_addr;
    logic [BL_W-1:0]        cmd_bl;
    logic                   cmd_full;
    logic                   beat_strobe;
    logic                   busy;
    logic                   err;

    sdram_port_arb #(.NREQ(NREQ), .ADDR_W(ADDR_W), .BL_W(BL_W)) dut (
        .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
        .req_bl(req_bl), .gnt(gnt), .done(done), .cmd_en(cmd_en),
        .cmd_instr(cmd_instr), .cmd_addr(cmd_addr), .cmd_bl(cmd_bl),
        .cmd_full(cmd_full), .beat_strobe(beat_strobe), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         idx;
        logic       wr;
        logic [29:0] addr;
        logic [5:0] bl;
        logic [3:0] exp_gnt;
        logic [2:0] exp_instr;
    } vec_t;

    vec_t vecs [5];
    int   checks = 0;
    int   errors = 0;
    int   glog [8];
    int   gcount, min_gap, en_total;
    int   exp_order2 [5];
    int   exp_order6 [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req = '0;
        beat_strobe = 1'b0;
        cmd_full = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    function automatic int oh_idx(input logic [3:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic set_slice(input int idx, input logic wr, input logic [29:0] addr, input logic [5:0] bl);
        req_wr[idx] = wr;
        req_addr[idx*ADDR_W +: ADDR_W] = addr;
        req_bl[idx*BL_W +: BL_W] = bl;
    endtask

    // One complete single-requester burst with cmd_full low.
    task automatic run_txn(input int idx, input logic wr, input logic [29:0] addr,
                           input logic [5:0] bl, input logic [3:0] exp_gnt,
                           input logic [2:0] exp_instr);
        int anomalies;
        anomalies = 0;
        set_slice(idx, wr, addr, bl);
        req[idx] = 1'b1;
        tick;
        chk("gnt", gnt, exp_gnt);
        chk("busy_grant", busy, 1);
        chk("cmd_en_grant_cycle", cmd_en, 0);
        tick;
        chk("cmd_en_pulse", cmd_en, 1);
        chk("cmd_instr", cmd_instr, exp_instr);
        chk("cmd_addr", cmd_addr, addr);
        chk("cmd_bl", cmd_bl, bl);
        if (!wr) begin
            beat_strobe = 1'b1;
            for (int i = 0; i <= int'(bl); i++) begin
                tick;
                if (cmd_en) anomalies++;
                if (i < int'(bl) && done != 0) anomalies++;
            end
            beat_strobe = 1'b0;
        end else begin
            tick;
        end
        req[idx] = 1'b0;
        chk("done_pulse", done, exp_gnt);
        chk("gnt_released", gnt, 0);
        chk("busy_released", busy, 0);
        chk("cmd_en_single", cmd_en, 0);
        chk("no_early_done_or_extra_cmd", anomalies, 0);
        tick;
        chk("done_one_cycle", done, 0);
        $display("txn req%0d wr=%0b addr=%h bl=%0d gnt=%b instr=%b", idx, wr, addr, bl, exp_gnt, exp_instr);
    endtask

    // Hold the masked requesters (reads, bl 0) and log the first n grants.
    task automatic run_multi(input logic [3:0] mask, input int n);
        logic [3:0] prev;
        int gap;
        for (int i = 0; i < NREQ; i++) if (mask[i]) set_slice(i, 1'b0, 30'(i * 32'h100), 6'd0);
        gcount = 0; min_gap = 99; en_total = 0; gap = 0; prev = '0;
        beat_strobe = 1'b0;
        req = mask;
        for (int c = 0; c < 300 && !(gcount >= n && !busy && done == 0 && !beat_strobe); c++) begin
            tick;
            if (cmd_en) en_total++;
            if (gnt != 0 && prev == 0) begin
                if (gcount > 0 && gap < min_gap) min_gap = gap;
                if (gcount < 8) glog[gcount] = oh_idx(gnt);
                $display("grant %0d -> req%0d", gcount, oh_idx(gnt));
                gcount++;
                if (gcount == n) req = '0;
            end
            if (gnt == 0) gap++;
            else gap = 0;
            prev = gnt;
            beat_strobe = cmd_en;
        end
        beat_strobe = 1'b0;
        chk("grant_count", gcount, n);
        chk("cmd_en_per_grant", en_total, n);
        chk("idle_gap", min_gap, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_seen, dn_seen;
        vecs[0] = '{1, 1'b0, 30'h00A0000,  6'd7,  4'b0010, 3'b001};
        vecs[1] = '{0, 1'b1, 30'h0001234,  6'd3,  4'b0001, 3'b000};
        vecs[2] = '{2, 1'b0, 30'h3FFFFFC0, 6'd63, 4'b0100, 3'b001};
        vecs[3] = '{3, 1'b1, 30'h0000100,  6'd0,  4'b1000, 3'b000};
        vecs[4] = '{3, 1'b0, 30'h0000040,  6'd0,  4'b1000, 3'b001};
`ifdef ARB_FIXED_PRIO0_EN
        exp_order2 = '{0, 0, 0, 0, 0};
        exp_order6 = '{0, 0, 0, 0};
`else
        exp_order2 = '{0, 1, 2, 3, 0};
        exp_order6 = '{0, 2, 0, 2};
`endif
        req_wr = '0; req_addr = '0; req_bl = '0;
        do_reset;
        // Reset state.
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_cmd_en", cmd_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_cmd_addr", cmd_addr, 0);

        // Single-requester bursts, including the 64-beat maximum.
        for (int v = 0; v < 5; v++)
            run_txn(vecs[v].idx, vecs[v].wr, vecs[v].addr, vecs[v].bl, vecs[v].exp_gnt, vecs[v].exp_instr);
        chk("err_after_table", err, 0);

        // All four requesters held: round-robin rotation from reset.
        do_reset;
        run_multi(4'b1111, 5);
        for (int i = 0; i < 5; i++) chk($sformatf("rr_order_%0d", i), glog[i], exp_order2[i]);
        chk("err_after_rr", err, 0);

        // Write with command FIFO full for five ISSUE cycles.
        do_reset;
        set_slice(3, 1'b1, 30'h0000100, 6'd15);
        cmd_full = 1'b1;
        req[3] = 1'b1;
        tick;
        chk("full_gnt", gnt, 4'b1000);
        en_seen = 0;
        repeat (5) begin
            tick;
            if (cmd_en) en_seen++;
        end
        chk("full_no_cmd_en", en_seen, 0);
        chk("full_busy", busy, 1);
        cmd_full = 1'b0;
        tick;
        chk("full_release_cmd_en", cmd_en, 1);
        chk("full_release_instr", cmd_instr, 3'b000);
        chk("full_release_bl", cmd_bl, 15);
        req[3] = 1'b0;
        tick;
        chk("full_done", done, 4'b1000);
        chk("full_cmd_en_low", cmd_en, 0);
        chk("full_busy_low", busy, 0);
        $display("txn backpressure write req3 done");

        // Reset mid-read after 3 of 8 beats.
        do_reset;
        set_slice(1, 1'b0, 30'h0002000, 6'd7);
        req[1] = 1'b1;
        tick;
        tick;
        chk("mid_cmd_en", cmd_en, 1);
        beat_strobe = 1'b1;
        repeat (3) tick;
        beat_strobe = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_rst_gnt", gnt, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_cmd_en", cmd_en, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_addr", cmd_addr, 0);
        req = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        dn_seen = 0;
        repeat (3) begin
            tick;
            if (done != 0) dn_seen++;
        end
        chk("abandoned_no_done", dn_seen, 0);
        run_txn(2, 1'b0, 30'h0003000, 6'd1, 4'b0100, 3'b001);

        // Stray beat in IDLE sets sticky err.
        chk("err_clear_before_stray", err, 0);
        beat_strobe = 1'b1;
        tick;
        beat_strobe = 1'b0;
        tick;
        chk("err_set", err, 1);
        run_txn(1, 1'b0, 30'h0000800, 6'd2, 4'b0010, 3'b001);
        chk("err_sticky", err, 1);
        do_reset;
        chk("err_cleared_by_rst", err, 0);

        // Requesters 0 and 2 held.
        run_multi(4'b0101, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("prio_order_%0d", i), glog[i], exp_order6[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
